// File: rtl/slow_edge_pkg.sv
// Shared types and defaults for the slow-edge round-robin arbiter.
//
// Contents:
//   sea_state_e        lock-tracking FSM states
//   SEA_NUM_REQ_DEF    default number of requesters
//   SEA_TIMEOUT_DEF    default stall timeout in clk_fast cycles
//   sea_is_tracking()  true while a slow period is being followed
package slow_edge_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    STALLED  = 2'd3
  } sea_state_e;

  localparam int SEA_NUM_REQ_DEF = 4;
  localparam int SEA_TIMEOUT_DEF = 256;

  // The stall watchdog only applies once at least one edge has been seen
  // since the last loss of lock.
  function automatic logic sea_is_tracking(input sea_state_e s);
    return (s == LOCKING) || (s == LOCKED);
  endfunction

endpackage

// File: rtl/slow_edge_sync.sv
// Synchroniser and rising-edge detector for a slow clock sampled as data.
//
// Ports:
//   clk_i       in   fast sampling clock, posedge
//   rst_i       in   synchronous reset, active-high
//   async_i     in   slow clock, asynchronous to clk_i
//   edge_raw_o  out  combinational rising-edge indication (sync2 & ~prev)
//   edge_stb_o  out  registered 1-cycle strobe, one cycle after edge_raw_o
//
// The raw indication is exported so the parent can register its own
// edge-qualified state in the same clock as edge_stb_o rises.
module slow_edge_sync
  import slow_edge_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_raw_o,
  output logic edge_stb_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic stb_q;

  // High for exactly one cycle per rising edge, provided the slow clock
  // stays high for at least two sampling cycles.
  assign edge_raw_o = sync2_q & ~prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      stb_q   <= edge_raw_o;
    end
  end

  assign edge_stb_o = stb_q;

endmodule

// File: rtl/slow_edge_arbiter.sv
// Round-robin grant scheduler paced by rising edges of a slow clock that is
// sampled in the clk_fast domain. At most one one-hot grant is issued per
// slow edge, the slow period is measured in clk_fast cycles, and a stopped
// slow clock drops lock and suppresses grants until two fresh edges re-lock.
//
// Ports:
//   clk_fast     in   single clock, all flops on posedge
//   rst          in   synchronous reset, active-high
//   clk_slow     in   slow clock, treated as asynchronous data
//   req_i        in   [NUM_REQ] level requests
//   gnt_o        out  [NUM_REQ] one-hot grant pulse, coincident with slow_edge_o
//   slow_edge_o  out  1-cycle strobe per detected slow rising edge
//   locked_o     out  period measured and stable, grants enabled
//   stalled_o    out  no slow edge seen for TIMEOUT_CYCLES
//   period_o     out  [CNT_W] clk_fast cycles between the last two edges
//   state_o      out  current FSM state (debug visibility)
//
// Request/grant contract: a requester raises req_i and holds it until it
// sees its bit of gnt_o; it drops req_i on the following cycle. There is
// no back-pressure. Requests are sampled only in the cycle the slow edge is
// detected, so a request withdrawn before that cycle is never granted.
module slow_edge_arbiter
  import slow_edge_pkg::*;
#(
  parameter  int NUM_REQ        = SEA_NUM_REQ_DEF,
  parameter  int TIMEOUT_CYCLES = SEA_TIMEOUT_DEF,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk_fast,
  input  logic               rst,
  input  logic               clk_slow,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               slow_edge_o,
  output logic               locked_o,
  output logic               stalled_o,
  output logic [CNT_W-1:0]   period_o,
  output sea_state_e         state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic edge_raw;
  logic edge_stb;

  slow_edge_sync u_sync (
    .clk_i      (clk_fast),
    .rst_i      (rst),
    .async_i    (clk_slow),
    .edge_raw_o (edge_raw),
    .edge_stb_o (edge_stb)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  sea_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  // Number of cycles since the previous edge, counting this edge cycle.
  // Only consumed while tracking, where cnt_q never exceeds CNT_LAST, so
  // the increment cannot overflow.
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + CNT_W'(1);

  logic timeout_hit;
  assign timeout_hit = sea_is_tracking(state_q) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------
  // Round-robin winner search: first set request at or after ptr_q
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   ptr_after_win;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign win_onehot    = NUM_REQ'(1) << win_idx;
  assign ptr_after_win = (win_idx == PTR_MAX) ? '0 : (win_idx + PTR_W'(1));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;

    // Free-running period counter, restarted by every edge.
    if (edge_raw) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_inc;
    end

    // Edge takes priority over timeout in every state, so an edge landing
    // on the last allowed cycle still counts as a valid period.
    unique case (state_q)
      UNLOCKED: begin
        if (edge_raw) state_d = LOCKING;
      end
      LOCKING: begin
        if (edge_raw) begin
          state_d  = LOCKED;
          period_d = cnt_inc;
        end else if (timeout_hit) begin
          state_d = STALLED;
        end
      end
      LOCKED: begin
        if (edge_raw) begin
          period_d = cnt_inc;
          if (win_found) begin
            gnt_d = win_onehot;
            ptr_d = ptr_after_win;
          end
        end else if (timeout_hit) begin
          state_d = STALLED;
        end
      end
      STALLED: begin
        if (edge_raw) state_d = LOCKING;
      end
      default: begin
        state_d = UNLOCKED;
      end
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      cnt_q    <= '0;
      period_q <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign gnt_o       = gnt_q;
  assign slow_edge_o = edge_stb;
  assign locked_o    = (state_q == LOCKED);
  assign stalled_o   = (state_q == STALLED);
  assign period_o    = period_q;
  assign state_o     = state_q;

  // ---------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------
  a_gnt_onehot : assert property (@(posedge clk_fast) disable iff (rst)
    $onehot0(gnt_o));

  a_gnt_with_edge : assert property (@(posedge clk_fast) disable iff (rst)
    (|gnt_o) |-> slow_edge_o);

  a_locked_xor_stalled : assert property (@(posedge clk_fast) disable iff (rst)
    !(locked_o && stalled_o));

endmodule
